// File: rtl/cdb_arbiter_if.sv
// FU-result / common-data-bus bundle between the execute-stage FU array and cdb_arbiter.
// master = arbiter side (drives sel and cdb); slave = FU array / consumers side.
interface cdb_arbiter_if #(
   parameter int N_FU      = 8,
   parameter int CDB_WIDTH = 2
);
   localparam int VAL_W  = 32;
   localparam int PRF_W  = 6;
   localparam int ROB_W  = 5;
   localparam int ADDR_W = 32;

   typedef struct packed {
      logic              valid;
      logic [VAL_W-1:0]  value;
      logic              value_valid;
      logic [PRF_W-1:0]  dest_prf;
      logic [ROB_W-1:0]  rob_entry;
      logic [ADDR_W-1:0] branch_address;
   } FUNC_OUTPUT;

   typedef struct packed {
      logic              valid;
      logic [VAL_W-1:0]  value;
      logic              value_valid;
      logic [PRF_W-1:0]  dest_prf;
      logic [ROB_W-1:0]  rob_entry;
      logic              is_branch;
      logic [ADDR_W-1:0] branch_address;
   } CDB_PACKET;

   FUNC_OUTPUT      fu_out [N_FU];
   logic            squash;
   logic [N_FU-1:0] sel;
   CDB_PACKET       cdb [CDB_WIDTH];

   modport master (input fu_out, input squash, output sel, output cdb);
   modport slave  (output fu_out, output squash, input sel, input cdb);
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin completion arbiter: grants up to CDB_WIDTH valid FUs per cycle onto a registered CDB.
// Optional macro CDB_PERF_CNT_EN adds perf_bcast_cnt / perf_stall_cnt counters.
module cdb_arbiter #(
   parameter int              N_FU           = 8,
   parameter int              CDB_WIDTH      = 2,
   parameter logic [N_FU-1:0] BRANCH_FU_MASK = N_FU'(8'b0000_0001)
) (
   input  logic          clock,
   input  logic          reset,
   cdb_arbiter_if.master cdb_bus
`ifdef CDB_PERF_CNT_EN
   ,
   output logic [31:0]   perf_bcast_cnt,
   output logic [31:0]   perf_stall_cnt
`endif
);
   localparam int PTR_W  = (N_FU > 1) ? $clog2(N_FU) : 1;
   localparam int CNT_W  = $clog2(N_FU + 1);
   localparam int VAL_W  = 32;
   localparam int PRF_W  = 6;
   localparam int ROB_W  = 5;
   localparam int ADDR_W = 32;

   typedef struct packed {
      logic              valid;
      logic [VAL_W-1:0]  value;
      logic              value_valid;
      logic [PRF_W-1:0]  dest_prf;
      logic [ROB_W-1:0]  rob_entry;
      logic              is_branch;
      logic [ADDR_W-1:0] branch_address;
   } slot_t;

   logic [PTR_W-1:0] rr_q, rr_d;
   slot_t            cdb_q [CDB_WIDTH];
   slot_t            cdb_d [CDB_WIDTH];
   logic [N_FU-1:0]  valid_vec, grant;
   logic [CNT_W-1:0] n_grant;
   logic [PTR_W:0]   scan_sum, next_sum;
   logic [PTR_W-1:0] idx, last_idx;

   // Grant stage: scan from rr_q with wrap, pack winners into slots 0.. in scan order.
   always_comb begin
      grant    = '0;
      n_grant  = '0;
      rr_d     = rr_q;
      scan_sum = '0;
      next_sum = '0;
      idx      = '0;
      last_idx = rr_q;
      for (int k = 0; k < CDB_WIDTH; k++) cdb_d[k] = '0;
      for (int i = 0; i < N_FU; i++) valid_vec[i] = cdb_bus.fu_out[i].valid;

      for (int off = 0; off < N_FU; off++) begin
         scan_sum = {1'b0, rr_q} + (PTR_W+1)'(off);
         if (scan_sum >= (PTR_W+1)'(N_FU)) scan_sum = scan_sum - (PTR_W+1)'(N_FU);
         idx = scan_sum[PTR_W-1:0];
         if (valid_vec[idx] && (n_grant < CNT_W'(CDB_WIDTH))) begin
            grant[idx] = 1'b1;
            for (int k = 0; k < CDB_WIDTH; k++) begin
               if (n_grant == CNT_W'(k)) begin
                  cdb_d[k].valid          = 1'b1;
                  cdb_d[k].value          = cdb_bus.fu_out[idx].value;
                  cdb_d[k].value_valid    = cdb_bus.fu_out[idx].value_valid;
                  cdb_d[k].dest_prf       = cdb_bus.fu_out[idx].dest_prf;
                  cdb_d[k].rob_entry      = cdb_bus.fu_out[idx].rob_entry;
                  cdb_d[k].is_branch      = BRANCH_FU_MASK[idx];
                  cdb_d[k].branch_address = BRANCH_FU_MASK[idx] ?
                                            cdb_bus.fu_out[idx].branch_address : '0;
               end
            end
            n_grant  = n_grant + 1'b1;
            last_idx = idx;
         end
      end

      if (n_grant != '0) begin
         next_sum = {1'b0, last_idx} + 1'b1;
         if (next_sum == (PTR_W+1)'(N_FU)) next_sum = '0;
         rr_d = next_sum[PTR_W-1:0];
      end

      // Squash drains every valid FU but broadcasts nothing and restarts the scan at 0.
      if (cdb_bus.squash) begin
         grant = valid_vec;
         rr_d  = '0;
         for (int k = 0; k < CDB_WIDTH; k++) cdb_d[k] = '0;
      end

      if (reset) grant = '0;
   end

   assign cdb_bus.sel = grant;

   always_comb begin
      for (int k = 0; k < CDB_WIDTH; k++) cdb_bus.cdb[k] = cdb_q[k];
   end

   // Broadcast stage: registered CDB slots and round-robin pointer.
   always_ff @(posedge clock) begin
      if (reset) begin
         rr_q <= '0;
         for (int k = 0; k < CDB_WIDTH; k++) cdb_q[k] <= '0;
      end else begin
         rr_q <= rr_d;
         for (int k = 0; k < CDB_WIDTH; k++) cdb_q[k] <= cdb_d[k];
      end
   end

`ifdef CDB_PERF_CNT_EN
   logic [CNT_W-1:0] n_valid;
   logic [31:0]      bcast_q, stall_q;

   always_comb begin
      n_valid = '0;
      for (int i = 0; i < N_FU; i++) n_valid = n_valid + CNT_W'(valid_vec[i]);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         bcast_q <= '0;
         stall_q <= '0;
      end else if (!cdb_bus.squash) begin
         bcast_q <= bcast_q + 32'(n_grant);
         stall_q <= stall_q + 32'(n_valid - n_grant);
      end
   end

   assign perf_bcast_cnt = bcast_q;
   assign perf_stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed table-driven bench for cdb_arbiter (N_FU=8, CDB_WIDTH=2, FU0 is the branch unit).
module tb_cdb_arbiter;
   localparam int        N_FU      = 8;
   localparam int        CDB_WIDTH = 2;
   localparam logic [7:0] BR_MASK  = 8'b0000_0001;

   typedef struct packed {
      logic        valid;
      logic [31:0] value;
      logic        value_valid;
      logic [5:0]  dest_prf;
      logic [4:0]  rob_entry;
      logic        is_branch;
      logic [31:0] branch_address;
   } slot_t;

   typedef struct {
      logic [7:0] valid;
      logic       sq;
      logic [7:0] sel;
      int         s0;
      int         s1;
   } vec_t;

   logic clock = 1'b0;
   logic reset;
   int   tests = 0;
   int   fails = 0;
   vec_t vt [16];

   always #5 clock = ~clock;

   cdb_arbiter_if #(.N_FU(N_FU), .CDB_WIDTH(CDB_WIDTH)) bus ();

`ifdef CDB_PERF_CNT_EN
   logic [31:0] perf_bcast_cnt, perf_stall_cnt;
   logic [31:0] exp_bcast = 0, exp_stall = 0;
`endif

   cdb_arbiter #(.N_FU(N_FU), .CDB_WIDTH(CDB_WIDTH), .BRANCH_FU_MASK(BR_MASK)) dut (
      .clock   (clock),
      .reset   (reset),
      .cdb_bus (bus)
`ifdef CDB_PERF_CNT_EN
      ,
      .perf_bcast_cnt (perf_bcast_cnt),
      .perf_stall_cnt (perf_stall_cnt)
`endif
   );

   function automatic logic [31:0] fu_value(int i, int tag);
      return 32'hA000_0000 + 32'(i * 256 + tag);
   endfunction

   function automatic logic [31:0] fu_addr(int i, int tag);
      return 32'hDEAD_0000 + 32'(i * 16 + tag);
   endfunction

   function automatic slot_t exp_slot(int fu, int tag);
      slot_t s = '0;
      if (fu >= 0) begin
         s.valid          = 1'b1;
         s.value          = fu_value(fu, tag);
         s.value_valid    = 1'(fu & 1);
         s.dest_prf       = 6'(fu + tag);
         s.rob_entry      = 5'(3 * fu + tag);
         s.is_branch      = BR_MASK[fu];
         s.branch_address = BR_MASK[fu] ? fu_addr(fu, tag) : 32'h0;
      end
      return s;
   endfunction

   task automatic drive_fus(input logic [7:0] mask, input int tag);
      for (int i = 0; i < N_FU; i++) begin
         bus.fu_out[i].valid          = mask[i];
         bus.fu_out[i].value          = fu_value(i, tag);
         bus.fu_out[i].value_valid    = 1'(i & 1);
         bus.fu_out[i].dest_prf       = 6'(i + tag);
         bus.fu_out[i].rob_entry      = 5'(3 * i + tag);
         bus.fu_out[i].branch_address = fu_addr(i, tag);
      end
   endtask

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_cdb(input string name, input slot_t e0, input slot_t e1);
      slot_t a0, a1;
      a0 = bus.cdb[0];
      a1 = bus.cdb[1];
      chk({name, ".slot0"}, 128'(a0), 128'(e0));
      chk({name, ".slot1"}, 128'(a1), 128'(e1));
   endtask

   initial begin
      //           valid  sq    sel    s0  s1
      vt[0]  = '{8'h08, 1'b0, 8'h08,  3, -1};
      vt[1]  = '{8'hFF, 1'b0, 8'h30,  4,  5};
      vt[2]  = '{8'hFF, 1'b0, 8'hC0,  6,  7};
      vt[3]  = '{8'hFF, 1'b0, 8'h03,  0,  1};
      vt[4]  = '{8'hFF, 1'b0, 8'h0C,  2,  3};
      vt[5]  = '{8'hFF, 1'b0, 8'h30,  4,  5};
      vt[6]  = '{8'hFF, 1'b0, 8'hC0,  6,  7};
      vt[7]  = '{8'hFF, 1'b0, 8'h03,  0,  1};
      vt[8]  = '{8'h00, 1'b0, 8'h00, -1, -1};
      vt[9]  = '{8'h40, 1'b0, 8'h40,  6, -1};
      vt[10] = '{8'h82, 1'b0, 8'h82,  7,  1};
      vt[11] = '{8'h03, 1'b0, 8'h03,  0,  1};
      vt[12] = '{8'h64, 1'b1, 8'h64, -1, -1};
      vt[13] = '{8'h05, 1'b0, 8'h05,  0,  2};
      vt[14] = '{8'h03, 1'b0, 8'h03,  0,  1};
      vt[15] = '{8'h81, 1'b0, 8'h81,  7,  0};

      reset      = 1'b1;
      bus.squash = 1'b0;
      drive_fus(8'h12, 0);
      @(negedge clock);
      chk("reset.sel", 128'(bus.sel), 128'(8'h00));
      @(posedge clock); #1;
      chk_cdb("reset.cdb", '0, '0);
`ifdef CDB_PERF_CNT_EN
      chk("reset.bcast", 128'(perf_bcast_cnt), 128'(0));
      chk("reset.stall", 128'(perf_stall_cnt), 128'(0));
`endif
      @(negedge clock);
      reset = 1'b0;

      for (int i = 0; i < 16; i++) begin
         if (i > 0) @(negedge clock);
         drive_fus(vt[i].valid, i);
         bus.squash = vt[i].sq;
         #1;
         chk($sformatf("vec%0d.sel", i), 128'(bus.sel), 128'(vt[i].sel));
`ifdef CDB_PERF_CNT_EN
         if (!vt[i].sq) begin
            int g;
            g = (vt[i].s0 >= 0 ? 1 : 0) + (vt[i].s1 >= 0 ? 1 : 0);
            exp_bcast += 32'(g);
            exp_stall += 32'($countones(vt[i].valid) - g);
         end
`endif
         @(posedge clock); #1;
         chk_cdb($sformatf("vec%0d.cdb", i), exp_slot(vt[i].s0, i), exp_slot(vt[i].s1, i));
      end
`ifdef CDB_PERF_CNT_EN
      chk("table.bcast", 128'(perf_bcast_cnt), 128'(exp_bcast));
      chk("table.stall", 128'(perf_stall_cnt), 128'(exp_stall));
`endif

      // Squash while a broadcast is already registered: it stays visible, then clears.
      @(negedge clock);
      drive_fus(8'h20, 20);
      bus.squash = 1'b0;
      @(posedge clock); #1;
      chk_cdb("presquash.cdb", exp_slot(5, 20), '0);
      @(negedge clock);
      drive_fus(8'h64, 21);
      bus.squash = 1'b1;
      #1;
      chk("squash.sel", 128'(bus.sel), 128'(8'h64));
      chk_cdb("squash.held", exp_slot(5, 20), '0);
      @(posedge clock); #1;
      chk_cdb("squash.cdb", '0, '0);
`ifdef CDB_PERF_CNT_EN
      chk("squash.bcast", 128'(perf_bcast_cnt), 128'(exp_bcast + 1));
      chk("squash.stall", 128'(perf_stall_cnt), 128'(exp_stall));
`endif
      @(negedge clock);
      drive_fus(8'h81, 22);
      bus.squash = 1'b0;
      #1;
      chk("postsquash.sel", 128'(bus.sel), 128'(8'h81));
      @(posedge clock); #1;
      chk_cdb("postsquash.cdb", exp_slot(0, 22), exp_slot(7, 22));

      // Reset mid-stream: pointer moved to 4 first, then reset with FUs 1 and 4 valid.
      @(negedge clock);
      drive_fus(8'h08, 23);
      @(posedge clock); #1;
      chk_cdb("prereset.cdb", exp_slot(3, 23), '0);
      @(negedge clock);
      drive_fus(8'h12, 24);
      reset = 1'b1;
      #1;
      chk("midreset.sel", 128'(bus.sel), 128'(8'h00));
      @(posedge clock); #1;
      chk_cdb("midreset.cdb", '0, '0);
`ifdef CDB_PERF_CNT_EN
      chk("midreset.bcast", 128'(perf_bcast_cnt), 128'(0));
      chk("midreset.stall", 128'(perf_stall_cnt), 128'(0));
`endif
      @(negedge clock);
      reset = 1'b0;
      drive_fus(8'h81, 25);
      #1;
      chk("postreset.sel", 128'(bus.sel), 128'(8'h81));
      @(posedge clock); #1;
      chk_cdb("postreset.cdb", exp_slot(0, 25), exp_slot(7, 25));
      @(negedge clock);
      drive_fus(8'h00, 26);
      @(posedge clock); #1;
      chk_cdb("idle.cdb", '0, '0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
